// File: rtl/xif_dmem_arbiter_pkg.sv
// rtl/xif_dmem_arbiter_pkg.sv - shared types and constants for the XIF/core data-RAM arbiter
package xif_dmem_arb_pkg;

  localparam int ID_W = 4;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_XIF  = 1'b1
  } owner_e;

  typedef struct packed {
    owner_e          owner;
    logic [ID_W-1:0] id;
  } route_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CWR  = 2'd1,
    GNT_CRD  = 2'd2,
    GNT_XIF  = 2'd3
  } grant_e;

  localparam logic [5:0] EXC_LD_FAULT = 6'd5;
  localparam logic [5:0] EXC_ST_FAULT = 6'd7;

endpackage

// File: rtl/xif_dmem_arbiter_if.sv
// rtl/xif_dmem_arbiter_if.sv - core, XIF mem/mem_result and data-RAM signal bundle
interface xif_dmem_arbiter_if;
  import xif_dmem_arb_pkg::*;

  logic            core_rreq, core_rack, core_rresp;
  logic [31:0]     core_raddr, core_rdata;
  logic            core_wreq, core_wack;
  logic [31:0]     core_waddr, core_wdata;
  logic [3:0]      core_wstrb;
  logic            x_mem_valid, x_mem_ready, x_mem_we, x_mem_exc;
  logic [ID_W-1:0] x_mem_id, x_res_id;
  logic [31:0]     x_mem_addr, x_mem_wdata, x_res_rdata;
  logic [3:0]      x_mem_be;
  logic [5:0]      x_mem_excode;
  logic            x_res_valid, x_res_err;
  logic            m_req, m_ack, m_we, m_rresp;
  logic [31:0]     m_addr, m_wdata, m_rdata;
  logic [3:0]      m_wstrb;

  modport slave (
    input  core_rreq, core_raddr, core_wreq, core_waddr, core_wdata, core_wstrb,
           x_mem_valid, x_mem_id, x_mem_addr, x_mem_we, x_mem_be, x_mem_wdata,
           m_ack, m_rresp, m_rdata,
    output core_rack, core_rresp, core_rdata, core_wack,
           x_mem_ready, x_mem_exc, x_mem_excode, x_res_valid, x_res_id, x_res_rdata, x_res_err,
           m_req, m_we, m_addr, m_wdata, m_wstrb
  );

  modport master (
    output core_rreq, core_raddr, core_wreq, core_waddr, core_wdata, core_wstrb,
           x_mem_valid, x_mem_id, x_mem_addr, x_mem_we, x_mem_be, x_mem_wdata,
           m_ack, m_rresp, m_rdata,
    input  core_rack, core_rresp, core_rdata, core_wack,
           x_mem_ready, x_mem_exc, x_mem_excode, x_res_valid, x_res_id, x_res_rdata, x_res_err,
           m_req, m_we, m_addr, m_wdata, m_wstrb
  );

endinterface

// File: rtl/xif_dmem_arbiter_route_fifo.sv
// rtl/xif_dmem_arbiter_route_fifo.sv - in-order FIFO recording the owner of each outstanding read
module xif_route_fifo
  import xif_dmem_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  route_t  push_data,
  input  logic    pop,
  output route_t  head,
  output logic    full,
  output logic    empty,
  output logic [PW:0] count
);

  route_t          mem_q [DEPTH];
  route_t          mem_d [DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW:0]     count_q, count_d;

  // Pointers are exactly PW bits wide, so increment wraps mod DEPTH.
  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) begin
      mem_d[wptr_q] = push_data;
      wptr_d        = wptr_q + 1'b1;
    end
    if (pop) rptr_d = rptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign head  = mem_q[rptr_q];
  assign count = count_q;
  assign full  = (count_q == (PW+1)'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/xif_dmem_arbiter.sv
// rtl/xif_dmem_arbiter.sv - shares the data-RAM port between core load/store and XIF memory requests
module xif_dmem_arbiter
  import xif_dmem_arb_pkg::*;
#(
  parameter int          OUTST      = 4,
  parameter int          STARVE_MAX = 8,
  parameter logic [31:0] DMEM_BASE  = 32'h0002_0000,
  parameter logic [31:0] DMEM_SIZE  = 32'h0002_0000
) (
  input logic               clk,
  input logic               reset,
  xif_dmem_arbiter_if.slave bus
);

  localparam int          CW         = $clog2(OUTST) + 1;
  localparam int          SW         = $clog2(STARVE_MAX + 1);
  localparam logic [31:0] DMEM_END   = DMEM_BASE + DMEM_SIZE;
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  grant_e          gnt_q, gnt_d, gnt;
  logic [SW-1:0]   starve_q, starve_d;
  logic [CW-1:0]   xout_q, xout_d;
  logic            res_valid_q, res_valid_d;
  logic [ID_W-1:0] res_id_q, res_id_d;
  logic [31:0]     res_rdata_q, res_rdata_d;

  logic            x_in_win, x_oow, pop, rd_room, cr_elig, x_elig, x_rd_push, x_pop;
  logic            fifo_push, fifo_full, fifo_empty;
  route_t          push_data, head;
  logic [CW-1:0]   fifo_count_unused;

  xif_route_fifo #(.DEPTH(OUTST)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count_unused)
  );

  always_comb begin
    x_in_win = (bus.x_mem_addr >= DMEM_BASE) && (bus.x_mem_addr < DMEM_END);
    x_oow    = bus.x_mem_valid && !x_in_win;
    pop      = bus.m_rresp && !fifo_empty;
    // A response in the same cycle frees the slot a new read can take.
    rd_room  = !fifo_full || pop;
    cr_elig  = bus.core_rreq && rd_room;
    // Stores wait for all XIF loads so mem_result, which has no ready, stays in order.
    x_elig   = bus.x_mem_valid && x_in_win && (bus.x_mem_we ? (xout_q == '0) : rd_room);

    if (gnt_q != GNT_NONE)                     gnt = gnt_q;
    else if (starve_q == STARVE_LIM && x_elig) gnt = GNT_XIF;
    else if (bus.core_wreq)                    gnt = GNT_CWR;
    else if (cr_elig)                          gnt = GNT_CRD;
    else if (x_elig)                           gnt = GNT_XIF;
    else                                       gnt = GNT_NONE;

    bus.m_req   = (gnt != GNT_NONE);
    bus.m_we    = 1'b0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    bus.m_wstrb = '0;
    case (gnt)
      GNT_CWR: begin
        bus.m_we    = 1'b1;
        bus.m_addr  = bus.core_waddr;
        bus.m_wdata = bus.core_wdata;
        bus.m_wstrb = bus.core_wstrb;
      end
      GNT_CRD: bus.m_addr = bus.core_raddr;
      GNT_XIF: begin
        bus.m_we    = bus.x_mem_we;
        bus.m_addr  = bus.x_mem_addr;
        bus.m_wdata = bus.x_mem_we ? bus.x_mem_wdata : 32'h0;
        bus.m_wstrb = bus.x_mem_we ? bus.x_mem_be : 4'h0;
      end
      default: ;
    endcase

    bus.core_wack    = bus.m_ack && (gnt == GNT_CWR);
    bus.core_rack    = bus.m_ack && (gnt == GNT_CRD);
    bus.x_mem_ready  = (bus.m_ack && (gnt == GNT_XIF)) || x_oow;
    bus.x_mem_exc    = x_oow;
    bus.x_mem_excode = !x_oow ? 6'd0 : (bus.x_mem_we ? EXC_ST_FAULT : EXC_LD_FAULT);

    gnt_d = (gnt != GNT_NONE && !bus.m_ack) ? gnt : GNT_NONE;

    x_rd_push       = bus.m_ack && (gnt == GNT_XIF) && !bus.x_mem_we;
    fifo_push       = bus.core_rack || x_rd_push;
    push_data.owner = (gnt == GNT_XIF) ? OWN_XIF : OWN_CORE;
    push_data.id    = (gnt == GNT_XIF) ? bus.x_mem_id : '0;

    x_pop  = pop && (head.owner == OWN_XIF);
    xout_d = xout_q + CW'(x_rd_push) - CW'(x_pop);

    if (bus.x_mem_ready)                              starve_d = '0;
    else if (bus.x_mem_valid && starve_q != STARVE_LIM) starve_d = starve_q + 1'b1;
    else                                              starve_d = starve_q;

    res_valid_d = 1'b0;
    res_id_d    = res_id_q;
    res_rdata_d = res_rdata_q;
    if (x_pop) begin
      res_valid_d = 1'b1;
      res_id_d    = head.id;
      res_rdata_d = bus.m_rdata;
    end else if (bus.m_ack && gnt == GNT_XIF && bus.x_mem_we) begin
      res_valid_d = 1'b1;
      res_id_d    = bus.x_mem_id;
      res_rdata_d = 32'h0;
    end

    bus.core_rresp  = pop && (head.owner == OWN_CORE);
    bus.core_rdata  = bus.core_rresp ? bus.m_rdata : 32'h0;
    bus.x_res_valid = res_valid_q;
    bus.x_res_id    = res_id_q;
    bus.x_res_rdata = res_rdata_q;
    bus.x_res_err   = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_q       <= GNT_NONE;
      starve_q    <= '0;
      xout_q      <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_rdata_q <= '0;
    end else begin
      gnt_q       <= gnt_d;
      starve_q    <= starve_d;
      xout_q      <= xout_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_rdata_q <= res_rdata_d;
    end
  end

endmodule

// File: tb/tb_xif_dmem_arbiter.sv
// tb/tb_xif_dmem_arbiter.sv - directed self-checking bench for xif_dmem_arbiter
module tb_xif_dmem_arbiter;
  import xif_dmem_arb_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  int   ack_cyc;

  always #5 clk = ~clk;

  xif_dmem_arbiter_if bus ();

  xif_dmem_arbiter #(
    .OUTST(4), .STARVE_MAX(8), .DMEM_BASE(32'h0002_0000), .DMEM_SIZE(32'h0002_0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.core_rreq = 0; bus.core_raddr = 0;
    bus.core_wreq = 0; bus.core_waddr = 0; bus.core_wdata = 0; bus.core_wstrb = 0;
    bus.x_mem_valid = 0; bus.x_mem_id = 0; bus.x_mem_addr = 0; bus.x_mem_we = 0;
    bus.x_mem_be = 0; bus.x_mem_wdata = 0;
    bus.m_ack = 0; bus.m_rresp = 0; bus.m_rdata = 0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    #2;
    chk("rst_m_req", bus.m_req, 0);
    chk("rst_x_res_valid", bus.x_res_valid, 0);
    chk("rst_x_ready", bus.x_mem_ready, 0);
    chk("rst_core_rresp", bus.core_rresp, 0);
    chk("rst_fifo_empty", dut.fifo_empty, 1);
    chk("rst_starve", 32'(dut.starve_q), 0);
    tick(); tick();
    reset = 1'b0;

    // 1: lone core read, response two cycles later
    bus.core_rreq = 1; bus.core_raddr = 32'h0002_0000; bus.m_ack = 1;
    mid();
    chk("t1_m_req", bus.m_req, 1);
    chk("t1_m_addr", bus.m_addr, 32'h0002_0000);
    chk("t1_core_rack", bus.core_rack, 1);
    tick(); bus.core_rreq = 0; bus.m_ack = 0;
    mid(); chk("t1_m_req_idle", bus.m_req, 0);
    tick(); bus.m_rresp = 1; bus.m_rdata = 32'hDEAD_BEEF;
    mid();
    chk("t1_core_rresp", bus.core_rresp, 1);
    chk("t1_core_rdata", bus.core_rdata, 32'hDEAD_BEEF);
    tick(); bus.m_rresp = 0;
    mid(); chk("t1_fifo_empty", dut.fifo_empty, 1);

    // 2: core write beats XIF load id 3
    tick();
    bus.core_wreq = 1; bus.core_waddr = 32'h0002_0010; bus.core_wdata = 32'h11; bus.core_wstrb = 4'hF;
    bus.x_mem_valid = 1; bus.x_mem_id = 3; bus.x_mem_addr = 32'h0002_0020; bus.x_mem_we = 0;
    bus.m_ack = 1;
    mid();
    chk("t2_cw_wack", bus.core_wack, 1);
    chk("t2_cw_m_we", bus.m_we, 1);
    chk("t2_cw_m_addr", bus.m_addr, 32'h0002_0010);
    chk("t2_cw_x_ready", bus.x_mem_ready, 0);
    tick(); bus.core_wreq = 0;
    mid();
    chk("t2_x_ready", bus.x_mem_ready, 1);
    chk("t2_x_m_addr", bus.m_addr, 32'h0002_0020);
    chk("t2_x_m_we", bus.m_we, 0);
    tick(); bus.x_mem_valid = 0; bus.m_ack = 0;
    bus.m_rresp = 1; bus.m_rdata = 32'hCAFE_0003;
    mid();
    chk("t2_no_core_rresp", bus.core_rresp, 0);
    chk("t2_res_not_yet", bus.x_res_valid, 0);
    tick(); bus.m_rresp = 0;
    mid();
    chk("t2_res_valid", bus.x_res_valid, 1);
    chk("t2_res_id", bus.x_res_id, 3);
    chk("t2_res_rdata", bus.x_res_rdata, 32'hCAFE_0003);
    tick();
    mid(); chk("t2_res_drop", bus.x_res_valid, 0);

    // grant lock: waiting core read keeps the grant over a later core write
    tick();
    bus.core_rreq = 1; bus.core_raddr = 32'h0002_0040; bus.m_ack = 0;
    mid(); chk("lk_addr_a", bus.m_addr, 32'h0002_0040);
    tick(); bus.core_wreq = 1; bus.core_waddr = 32'h0002_0050;
    mid();
    chk("lk_addr_b", bus.m_addr, 32'h0002_0040);
    chk("lk_we_b", bus.m_we, 0);
    tick(); bus.m_ack = 1;
    mid();
    chk("lk_rack", bus.core_rack, 1);
    chk("lk_no_wack", bus.core_wack, 0);
    tick(); bus.core_rreq = 0;
    mid();
    chk("lk_wack", bus.core_wack, 1);
    chk("lk_w_addr", bus.m_addr, 32'h0002_0050);
    tick(); bus.core_wreq = 0; bus.m_ack = 0; bus.m_rresp = 1; bus.m_rdata = 32'h1234;
    mid(); chk("lk_rdata", bus.core_rdata, 32'h1234);
    tick(); bus.m_rresp = 0;

    // 3: starvation override against a permanent core writer
    bus.core_wreq = 1; bus.core_waddr = 32'h0002_0080;
    bus.x_mem_valid = 1; bus.x_mem_id = 5; bus.x_mem_addr = 32'h0002_0100; bus.x_mem_we = 0;
    bus.m_ack = 1;
    ack_cyc = -1;
    for (int c = 0; c < 12; c++) begin
      mid();
      if (bus.x_mem_ready) begin
        ack_cyc = c;
        break;
      end
      tick();
    end
    chk("t3_ack_cycle", 32'(ack_cyc), 8);
    tick(); bus.core_wreq = 0; bus.x_mem_valid = 0; bus.m_ack = 0;
    mid(); chk("t3_starve_clr", 32'(dut.starve_q), 0);
    tick(); bus.m_rresp = 1; bus.m_rdata = 32'h55;
    tick(); bus.m_rresp = 0;
    mid();
    chk("t3_res_valid", bus.x_res_valid, 1);
    chk("t3_res_id", bus.x_res_id, 5);

    // 4: out-of-window XIF accesses; core still uses the RAM
    tick();
    bus.x_mem_valid = 1; bus.x_mem_id = 2; bus.x_mem_addr = 32'h0000_1000; bus.x_mem_we = 0;
    bus.core_wreq = 1; bus.core_waddr = 32'h0002_0060; bus.m_ack = 1;
    mid();
    chk("t4_ld_ready", bus.x_mem_ready, 1);
    chk("t4_ld_exc", bus.x_mem_exc, 1);
    chk("t4_ld_excode", 32'(bus.x_mem_excode), 5);
    chk("t4_core_wack", bus.core_wack, 1);
    chk("t4_m_addr", bus.m_addr, 32'h0002_0060);
    tick(); bus.core_wreq = 0; bus.x_mem_addr = 32'h0004_0000; bus.x_mem_we = 1;
    mid();
    chk("t4_st_ready", bus.x_mem_ready, 1);
    chk("t4_st_excode", 32'(bus.x_mem_excode), 7);
    chk("t4_no_m_req", bus.m_req, 0);
    tick(); idle();
    mid(); chk("t4_no_result", bus.x_res_valid, 0);

    // 5: four reads fill the route FIFO, fifth waits for a response
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.core_rreq = 1; bus.core_raddr = 32'h0002_0200 + 32'(i * 4); bus.m_ack = 1;
      mid(); chk($sformatf("t5_rack%0d", i), bus.core_rack, 1);
    end
    tick(); bus.core_raddr = 32'h0002_0210;
    mid();
    chk("t5_full_rack", bus.core_rack, 0);
    chk("t5_full_m_req", bus.m_req, 0);
    tick();
    mid(); chk("t5_full_rack2", bus.core_rack, 0);
    tick(); bus.m_rresp = 1; bus.m_rdata = 32'hA0;
    mid();
    chk("t5_pp_rresp", bus.core_rresp, 1);
    chk("t5_pp_rdata", bus.core_rdata, 32'hA0);
    chk("t5_pp_rack", bus.core_rack, 1);
    tick(); bus.core_rreq = 0; bus.m_ack = 0;
    for (int j = 1; j < 5; j++) begin
      bus.m_rresp = 1; bus.m_rdata = 32'hA0 + 32'(j);
      mid(); chk($sformatf("t5_rdata%0d", j), bus.core_rdata, 32'hA0 + 32'(j));
      tick();
    end
    bus.m_rresp = 0;
    mid(); chk("t5_fifo_empty", dut.fifo_empty, 1);

    // 6: XIF store stalls behind an outstanding XIF load, then reset
    tick(); bus.core_rreq = 1; bus.core_raddr = 32'h0002_0400; bus.m_ack = 1;
    mid(); chk("t6_core_rack", bus.core_rack, 1);
    tick(); bus.core_rreq = 0;
    bus.x_mem_valid = 1; bus.x_mem_id = 1; bus.x_mem_addr = 32'h0002_0300; bus.x_mem_we = 0;
    mid(); chk("t6_ld_ready", bus.x_mem_ready, 1);
    tick();
    bus.x_mem_id = 2; bus.x_mem_addr = 32'h0002_0304; bus.x_mem_we = 1;
    bus.x_mem_wdata = 32'h77; bus.x_mem_be = 4'hF;
    mid();
    chk("t6_st_stall", bus.x_mem_ready, 0);
    chk("t6_st_no_req", bus.m_req, 0);
    tick(); bus.m_rresp = 1; bus.m_rdata = 32'hC0;
    mid();
    chk("t6_core_rresp", bus.core_rresp, 1);
    chk("t6_st_stall2", bus.x_mem_ready, 0);
    tick(); bus.m_rdata = 32'hB1;
    mid(); chk("t6_st_stall3", bus.x_mem_ready, 0);
    tick(); bus.m_rresp = 0;
    mid();
    chk("t6_ld_res_valid", bus.x_res_valid, 1);
    chk("t6_ld_res_id", bus.x_res_id, 1);
    chk("t6_ld_res_rdata", bus.x_res_rdata, 32'hB1);
    chk("t6_st_ready", bus.x_mem_ready, 1);
    chk("t6_st_m_we", bus.m_we, 1);
    chk("t6_st_m_wdata", bus.m_wdata, 32'h77);
    tick(); bus.x_mem_valid = 0; bus.core_rreq = 1; bus.core_raddr = 32'h0002_0500;
    mid();
    chk("t6_st_res_valid", bus.x_res_valid, 1);
    chk("t6_st_res_id", bus.x_res_id, 2);
    chk("t6_st_res_rdata", bus.x_res_rdata, 0);
    chk("t6_rack_pre_rst", bus.core_rack, 1);
    tick(); bus.core_rreq = 0; bus.m_ack = 0;
    mid(); chk("t6_fifo_busy", dut.fifo_empty, 0);
    reset = 1'b1;
    #1;
    chk("t6_rst_fifo_empty", dut.fifo_empty, 1);
    chk("t6_rst_m_req", bus.m_req, 0);
    chk("t6_rst_res_valid", bus.x_res_valid, 0);
    tick(); reset = 1'b0; bus.m_rresp = 1; bus.m_rdata = 32'hEE;
    mid();
    chk("t6_drop_rresp", bus.core_rresp, 0);
    chk("t6_drop_rdata", bus.core_rdata, 0);
    tick(); bus.m_rresp = 0;
    mid(); chk("t6_drop_res", bus.x_res_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
